// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions used by the fetch unit, instruction ROM and decode stage.
// Holds datapath widths, the reset PC and a word-alignment helper.
package cpu_defs;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_queue.sv
// Fetch queue: small synchronous FIFO with entry 0 always the head.
// Head storage is left untouched when the queue empties, so the head outputs hold their last value.
module fetch_queue #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 64,
    localparam int unsigned LvlW = $clog2(Depth) + 1,
    localparam int unsigned IdxW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [Width-1:0] din_i,
    output logic [LvlW-1:0]  level_o,
    output logic [Width-1:0] head_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [LvlW-1:0]  level_q, level_d;
    logic [IdxW-1:0]  wr_idx;

    always_comb begin
        mem_d   = mem_q;
        level_d = level_q;
        wr_idx  = IdxW'(level_q - LvlW'(pop_i));
        if (flush_i) begin
            level_d = '0;
        end else begin
            // Shift only when a valid entry moves into the head slot.
            if (pop_i && ((level_q > LvlW'(1)) || push_i)) begin
                for (int unsigned k = 0; k < Depth - 1; k++) begin
                    mem_d[k] = mem_q[k+1];
                end
            end
            if (push_i) begin
                mem_d[wr_idx] = din_i;
            end
            level_d = level_q + LvlW'(push_i) - LvlW'(pop_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= '0;
            for (int unsigned k = 0; k < Depth; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            level_q <= level_d;
            mem_q   <= mem_d;
        end
    end

    assign level_o = level_q;
    assign head_o  = mem_q[0];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the ROM address, queues fetched words
// and hands them to decode over a valid/ready handshake; redirects flush the queue.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned INST_W   = cpu_defs::INST_W,
    localparam int unsigned LvlW    = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic [31:0]       rom_a_o,
    input  logic [INST_W-1:0] rom_inst_i,
    input  logic              fetch_en_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] inst_out_o,
    output logic [31:0]       pc_out_o,
    output logic [LvlW-1:0]   q_level_o
);

    import cpu_defs::*;

    localparam int unsigned EntW = ADDR_W + INST_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pop, push;
    logic [LvlW-1:0]   level;
    logic [EntW-1:0]   head;

    assign inst_valid_o = (level != '0);
    assign pop          = inst_valid_o & inst_ready_i;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign push         = fetch_en_i & ~redirect_i & ((level < LvlW'(DEPTH)) | pop);

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = word_align(redirect_pc_i);
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_queue #(
        .Depth (DEPTH),
        .Width (EntW)
    ) u_fetch_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .din_i   ({pc_q, rom_inst_i}),
        .level_o (level),
        .head_o  (head)
    );

    assign rom_a_o    = pc_q;
    assign q_level_o  = level;
    assign pc_out_o   = head[EntW-1:INST_W];
    assign inst_out_o = head[INST_W-1:0];

endmodule
